// File: rtl/seq_signed_mult.sv
// Sequential radix-2 Booth multiplier for signed or unsigned operands.
// Each product takes B_W+1 Booth steps, one per clock. The full A_W+B_W-bit
// product is held on p, and done pulses for one cycle when a new p is valid.
module seq_signed_mult #(
  parameter int A_W = 16,
  parameter int B_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               sign_mode,
  input  logic [A_W-1:0]     a,
  input  logic [B_W-1:0]     b,
  output logic               busy,
  output logic               done,
  output logic [A_W+B_W-1:0] p
);

  // The accumulator has two guard bits above a, so adding or subtracting the
  // (A_W+1)-bit extended multiplicand can never overflow.
  localparam int ACC_W = A_W + 2;
  localparam int Q_W   = B_W + 1;
  localparam int CNT_W = $clog2(B_W + 2);
  localparam int P_W   = A_W + B_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [ACC_W-1:0]   mcand_q, mcand_d;
  logic [Q_W-1:0]     mplr_q, mplr_d;
  logic               guard_q, guard_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [P_W-1:0]     p_q, p_d;

  logic [ACC_W-1:0]   a_ext;
  logic [Q_W-1:0]     b_ext;
  logic [ACC_W-1:0]   acc_sum;
  logic [ACC_W-1:0]   acc_shift;
  logic [Q_W-1:0]     mplr_shift;
  logic               load;

  // Operand extension: sign_mode picks sign- or zero-extension. This lets the
  // same signed Booth datapath handle unsigned operands too.
  always_comb begin
    a_ext = sign_mode ? {{2{a[A_W-1]}}, a} : {2'b00, a};
    b_ext = sign_mode ? {b[B_W-1], b} : {1'b0, b};
  end

  // One Booth step: add or subtract the multiplicand based on {q0, q-1},
  // then arithmetic-shift {acc, q} right by one.
  always_comb begin
    acc_sum = acc_q;
    case ({mplr_q[0], guard_q})
      2'b01:   acc_sum = acc_q + mcand_q;
      2'b10:   acc_sum = acc_q - mcand_q;
      default: acc_sum = acc_q;
    endcase
    acc_shift  = {acc_sum[ACC_W-1], acc_sum[ACC_W-1:1]};
    mplr_shift = {acc_sum[0], mplr_q[Q_W-1:1]};
  end

  // Next-state and datapath update. A request is accepted only in IDLE or in
  // DONE; the DONE case gives back-to-back operation.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    mcand_d = mcand_q;
    mplr_d  = mplr_q;
    guard_d = guard_q;
    cnt_d   = cnt_q;
    p_d     = p_q;
    load    = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          load = 1'b1;
        end
      end
      CALC: begin
        acc_d   = acc_shift;
        mplr_d  = mplr_shift;
        guard_d = mplr_q[0];
        cnt_d   = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = DONE;
          // The product fits in the low A_W+B_W bits for both signednesses.
          p_d     = {acc_shift[A_W-2:0], mplr_shift};
        end
      end
      DONE: begin
        state_d = IDLE;
        if (start) begin
          load = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (load) begin
      state_d = CALC;
      acc_d   = '0;
      mcand_d = a_ext;
      mplr_d  = b_ext;
      guard_d = 1'b0;
      cnt_d   = CNT_W'(B_W + 1);
    end
  end

  // State and datapath registers. Reset clears everything, including p.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      mcand_q <= '0;
      mplr_q  <= '0;
      guard_q <= 1'b0;
      cnt_q   <= '0;
      p_q     <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      mcand_q <= mcand_d;
      mplr_q  <= mplr_d;
      guard_q <= guard_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
    end
  end

  // Status outputs are decoded directly from the state, so they can never
  // both be high at once.
  always_comb begin
    busy = (state_q == CALC);
    done = (state_q == DONE);
    p    = p_q;
  end

endmodule

// File: tb/tb_seq_signed_mult.sv
// Self-checking bench for seq_signed_mult with three instances (8x8, 16x16,
// 16x8). Products are compared with an integer-arithmetic reference model.
module tb_seq_signed_mult;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic [2:0] start_v = '0;
  logic [2:0] sm_v = '0;
  logic [2:0] busy_v;
  logic [2:0] done_v;

  logic [7:0]  a0 = '0, b0 = '0;
  logic [15:0] p0;
  logic [15:0] a1 = '0, b1 = '0;
  logic [31:0] p1;
  logic [15:0] a2 = '0;
  logic [7:0]  b2 = '0;
  logic [23:0] p2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seq_signed_mult #(.A_W(8), .B_W(8)) u_m8x8 (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .sign_mode(sm_v[0]),
    .a(a0), .b(b0), .busy(busy_v[0]), .done(done_v[0]), .p(p0)
  );

  seq_signed_mult #(.A_W(16), .B_W(16)) u_m16x16 (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .sign_mode(sm_v[1]),
    .a(a1), .b(b1), .busy(busy_v[1]), .done(done_v[1]), .p(p1)
  );

  seq_signed_mult #(.A_W(16), .B_W(8)) u_m16x8 (
    .clk(clk), .rst_n(rst_n), .start(start_v[2]), .sign_mode(sm_v[2]),
    .a(a2), .b(b2), .busy(busy_v[2]), .done(done_v[2]), .p(p2)
  );

  function automatic int aw_of(input int cfg);
    return (cfg == 0) ? 8 : 16;
  endfunction

  function automatic int bw_of(input int cfg);
    return (cfg == 1) ? 16 : 8;
  endfunction

  // Reference: interpret operands as integers and multiply, then wrap the
  // result to A_W+B_W bits.
  function automatic logic [63:0] ref_prod(input int cfg, input bit sm,
                                           input logic [63:0] av, input logic [63:0] bv);
    longint x, y, r;
    int aw, bw;
    aw = aw_of(cfg);
    bw = bw_of(cfg);
    x = longint'(av) & ((64'sd1 <<< aw) - 64'sd1);
    y = longint'(bv) & ((64'sd1 <<< bw) - 64'sd1);
    if (sm && av[aw-1]) x = x - (64'sd1 <<< aw);
    if (sm && bv[bw-1]) y = y - (64'sd1 <<< bw);
    r = x * y;
    return 64'(r) & ((64'd1 << (aw + bw)) - 64'd1);
  endfunction

  function automatic logic [63:0] get_p(input int cfg);
    case (cfg)
      0:       return 64'(p0);
      1:       return 64'(p1);
      default: return 64'(p2);
    endcase
  endfunction

  task automatic drive(input int cfg, input bit st, input bit sm,
                       input logic [63:0] av, input logic [63:0] bv);
    start_v[cfg] = st;
    sm_v[cfg] = sm;
    case (cfg)
      0: begin a0 = av[7:0];  b0 = bv[7:0];  end
      1: begin a1 = av[15:0]; b1 = bv[15:0]; end
      default: begin a2 = av[15:0]; b2 = bv[7:0]; end
    endcase
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Single directed product on one instance. It checks latency, busy length,
  // p, the one-cycle done pulse, and that p is held.
  task automatic run_op(input string tag, input int cfg, input bit sm,
                        input logic [63:0] av, input logic [63:0] bv,
                        input logic [63:0] exp_p);
    int n;
    int nb;
    @(negedge clk);
    drive(cfg, 1'b1, sm, av, bv);
    @(negedge clk);
    drive(cfg, 1'b0, 1'b0, 64'h0, 64'h0);
    n = 1;
    nb = 0;
    while (!done_v[cfg] && n < 40) begin
      if (busy_v[cfg]) nb++;
      @(negedge clk);
      n++;
    end
    check({tag, " latency"}, 64'(n - 1), 64'(bw_of(cfg) + 1));
    check({tag, " busy_cycles"}, 64'(nb), 64'(bw_of(cfg) + 1));
    check({tag, " busy_at_done"}, 64'(busy_v[cfg]), 64'd0);
    check({tag, " p"}, get_p(cfg), exp_p);
    $display("op %s cfg=%0d sm=%0d a=%0h b=%0h p=%0h latency=%0d",
             tag, cfg, sm, av, bv, get_p(cfg), n - 1);
    @(negedge clk);
    check({tag, " done_pulse"}, 64'(done_v[cfg]), 64'd0);
    check({tag, " p_held"}, get_p(cfg), exp_p);
  endtask

  initial begin
    int n;
    int dones;
    logic [2:0] seen;
    logic [63:0] exp_v [3];
    logic [63:0] ra, rb;
    bit rs;

    // Reset state.
    repeat (2) @(negedge clk);
    check("reset busy", 64'(busy_v), 64'd0);
    check("reset done", 64'(done_v), 64'd0);
    check("reset p8", 64'(p0), 64'd0);
    check("reset p16", 64'(p1), 64'd0);
    rst_n = 1'b1;

    // Directed corner products.
    run_op("neg128sq", 0, 1'b1, 64'h80, 64'h80, 64'h4000);
    run_op("neg128x127", 0, 1'b1, 64'h80, 64'h7F, 64'hC080);
    run_op("u255sq", 0, 1'b0, 64'hFF, 64'hFF, 64'hFE01);
    run_op("m1xneg128", 2, 1'b1, 64'hFFFF, 64'h80, 64'h000080);
    run_op("16bmin_sq", 1, 1'b1, 64'h8000, 64'h8000, 64'h40000000);
    run_op("u16max_sq", 1, 1'b0, 64'hFFFF, 64'hFFFF, 64'hFFFE0001);

    // A request made while busy is dropped.
    @(negedge clk);
    drive(0, 1'b1, 1'b1, 64'd3, 64'd5);
    @(negedge clk);
    drive(0, 1'b0, 1'b0, 64'd0, 64'd0);
    repeat (3) @(negedge clk);
    drive(0, 1'b1, 1'b1, 64'd7, 64'd7);
    @(negedge clk);
    drive(0, 1'b0, 1'b0, 64'd0, 64'd0);
    n = 5;
    while (!done_v[0] && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("busydrop latency", 64'(n - 1), 64'd9);
    check("busydrop p", 64'(p0), 64'h000F);
    $display("op busydrop p=%0h latency=%0d", p0, n - 1);
    dones = 0;
    repeat (25) begin
      @(negedge clk);
      if (done_v[0]) dones++;
    end
    check("busydrop no_second_done", 64'(dones), 64'd0);

    // Back-to-back: start held high, new operands presented in the DONE cycle.
    @(negedge clk);
    drive(0, 1'b1, 1'b1, 64'd3, 64'd5);
    @(negedge clk);
    n = 1;
    while (!done_v[0] && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("b2b first latency", 64'(n - 1), 64'd9);
    check("b2b first p", 64'(p0), 64'h000F);
    $display("op b2b_first p=%0h latency=%0d", p0, n - 1);
    drive(0, 1'b1, 1'b1, 64'hFE, 64'd4);
    @(negedge clk);
    drive(0, 1'b0, 1'b0, 64'd0, 64'd0);
    check("b2b reload busy", 64'(busy_v[0]), 64'd1);
    n = 1;
    while (!done_v[0] && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("b2b second latency", 64'(n - 1), 64'd9);
    check("b2b second p", 64'(p0), 64'hFFF8);
    $display("op b2b_second p=%0h latency=%0d", p0, n - 1);
    @(negedge clk);
    check("b2b done_pulse", 64'(done_v[0]), 64'd0);

    // Asynchronous reset in the middle of CALC.
    drive(0, 1'b1, 1'b1, 64'd3, 64'd5);
    @(negedge clk);
    drive(0, 1'b0, 1'b0, 64'd0, 64'd0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midreset busy", 64'(busy_v), 64'd0);
    check("midreset done", 64'(done_v), 64'd0);
    check("midreset p8", 64'(p0), 64'd0);
    check("midreset p16x8", 64'(p2), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    repeat (12) begin
      @(negedge clk);
      if (done_v[0]) dones++;
    end
    check("midreset no_stale_done", 64'(dones), 64'd0);
    $display("op midreset p=%0h", p0);
    run_op("after_reset", 0, 1'b1, 64'hFB, 64'd7, 64'hFFDD);

    // Random products on all three instances in parallel.
    for (int it = 0; it < 3400; it++) begin
      @(negedge clk);
      for (int c = 0; c < 3; c++) begin
        rs = 1'($urandom);
        ra = 64'($urandom) & ((64'd1 << aw_of(c)) - 64'd1);
        rb = 64'($urandom) & ((64'd1 << bw_of(c)) - 64'd1);
        exp_v[c] = ref_prod(c, rs, ra, rb);
        drive(c, 1'b1, rs, ra, rb);
      end
      @(negedge clk);
      for (int c = 0; c < 3; c++) drive(c, 1'b0, 1'b0, 64'd0, 64'd0);
      seen = '0;
      n = 1;
      while (seen != 3'b111 && n < 40) begin
        for (int c = 0; c < 3; c++) begin
          if (done_v[c] && !seen[c]) begin
            seen[c] = 1'b1;
            check($sformatf("random cfg%0d it%0d p", c, it), get_p(c), exp_v[c]);
          end
        end
        if (seen != 3'b111) begin
          @(negedge clk);
          n++;
        end
      end
      check($sformatf("random it%0d all_done", it), 64'(seen), 64'h7);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
